// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues requests to a combinational ALU, waits one settle
// cycle, captures result/flags and returns them on a valid/ready channel.
// Optional iteration count feeds the result back as operand A.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a request; req_ready=1
// S_ISSUE   | ALU operands presented, settle cycle
// S_CAPTURE | ALU outputs sampled at end of cycle; loop or respond
// S_REJECT  | invalid opcode latched; one cycle before the error response
// S_RESP    | response held until rsp_ready
module alu_op_sequencer #(
    parameter int N      = 8,
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [N-1:0]      req_a,
    input  logic [N-1:0]      req_b,
    input  logic              req_cin,
    input  logic [ITER_W-1:0] req_iter,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [3:0]        alu_sel,
    output logic              alu_cin,
    input  logic [N-1:0]      alu_result,
    input  logic              alu_neg,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_REJECT  = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [3:0] OP_MAX = 4'd9;

    state_t              state_q, state_d;
    logic [N-1:0]        alu_a_q, alu_a_d;
    logic [N-1:0]        alu_b_q, alu_b_d;
    logic [3:0]          alu_sel_q, alu_sel_d;
    logic                alu_cin_q, alu_cin_d;
    logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic [N-1:0]        rsp_result_q, rsp_result_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;

    // State and datapath registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            alu_cin_q    <= 1'b0;
            iter_cnt_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            alu_cin_q    <= alu_cin_d;
            iter_cnt_q   <= iter_cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        alu_cin_d    = alu_cin_q;
        iter_cnt_d   = iter_cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    iter_cnt_d = req_iter;
                    if (req_op <= OP_MAX) begin
                        // The ALU operand registers double as the latched request,
                        // so operands appear on the ALU during the ISSUE cycle.
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_sel_d = req_op;
                        alu_cin_d = req_cin;
                        state_d   = S_ISSUE;
                    end else begin
                        // ALU ports deliberately left untouched for a bad opcode.
                        rsp_result_d = '0;
                        rsp_flags_d  = 4'b0100;
                        rsp_err_d    = 1'b1;
                        state_d      = S_REJECT;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = {alu_neg, alu_zero, alu_cout, alu_ovf};
                rsp_err_d    = 1'b0;
                if (iter_cnt_q != '0) begin
                    alu_a_d    = alu_result;
                    iter_cnt_d = iter_cnt_q - 1'b1;
                    state_d    = S_ISSUE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_REJECT: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign alu_cin    = alu_cin_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule
